// File: rtl/gate_truth_checker_pkg.sv
// Shared types for the gate truth-table checker:
// FSM state encoding and common two-input truth tables.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Bit index of every table is {A,B}.
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_truth_checker_if.sv
// Two-input gate bus: A/B drive the gate, C is its output.
// master = checker side, slave = gate under test.
interface gate_truth_checker_if;
  logic A;
  logic B;
  logic C;

  modport master (output A, output B, input C);
  modport slave  (input A, input B, output C);
endinterface

// File: rtl/gate_truth_checker_settle_timer.sv
// settle_timer: counter with synchronous clear; tc is high
// when the count reaches CYCLES-1. Ports: clk, rst_n, clr, en, tc.
module settle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W =
    (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == W'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Steps {A,B} through 00..11, samples C after a settle time,
// scores it against EXPECTED_TT. Ports: clk, rst_n, start, gate bus, busy/done/pass/fail_idx/err_count.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED_TT   = NAND_TT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  gate_truth_checker_if.master        gate,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [1:0]                  fail_idx,
  output logic [2:0]                  err_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  fail_q, fail_d;
  logic [2:0]  err_q, err_d;
  logic        tmr_clr, tmr_en, tmr_tc;
  logic        mism;

  settle_timer #(.CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // idx_q doubles as the {A,B} drive register.
  assign gate.A    = idx_q[1];
  assign gate.B    = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_idx  = fail_q;
  assign err_count = err_q;

  // Case-inequality so an unknown C scores as a mismatch.
  assign mism = (gate.C !== EXPECTED_TT[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 2'd0;
          err_d   = 3'd0;
        end
      end
      ST_SETTLE: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        if (tmr_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mism) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) begin
            fail_d = idx_q;
          end
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_SETTLE;
        end else begin
          // Verdict is registered here so it is valid in the done cycle.
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == 3'd0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 2'd0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: three instances (default, fast, AND table)
// driven by programmable truth-table gate models and a reference scorer.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int         SC[3]  = '{2, 1, 2};
  localparam logic [3:0] ETT[3] = '{NAND_TT, NAND_TT, AND_TT};

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic       busy[3];
  logic       done[3];
  logic       pass[3];
  logic [1:0] fidx[3];
  logic [2:0] errc[3];
  logic [1:0] ab[3];
  logic [3:0] gtt[3];
  logic       dly_b;
  logic       p1, p2;

  int cyc = 0;
  int e0;
  int checks = 0;
  int errors = 0;
  int done_n[3] = '{0, 0, 0};
  int done_at[3] = '{0, 0, 0};

  gate_truth_checker_if ifa ();
  gate_truth_checker_if ifb ();
  gate_truth_checker_if ifc ();

  gate_truth_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .gate(ifa),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_idx(fidx[0]), .err_count(errc[0]));

  gate_truth_checker #(.SETTLE_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .gate(ifb),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_idx(fidx[1]), .err_count(errc[1]));

  gate_truth_checker #(.EXPECTED_TT(AND_TT)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .gate(ifc),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .fail_idx(fidx[2]), .err_count(errc[2]));

  assign ab[0] = {ifa.A, ifa.B};
  assign ab[1] = {ifb.A, ifb.B};
  assign ab[2] = {ifc.A, ifc.B};

  // Gate models; u_b's gate can be switched to a 2-cycle-late output.
  assign ifa.C = gtt[0][ab[0]];
  assign ifc.C = gtt[2][ab[2]];
  assign ifb.C = dly_b ? p2 : gtt[1][ab[1]];

  always @(posedge clk) begin
    p1 <= gtt[1][ab[1]];
    p2 <= p1;
    cyc <= cyc + 1;
  end

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        done_n[i]++;
        done_at[i] = cyc;
      end
    end
  end

  // Scores a run from the truth tables; with dly the gate sees the
  // vector driven before the current one (valid for 1-cycle settle).
  function automatic void ref_run(input logic [3:0] g, input logic [3:0] et,
                                  input bit dly, input logic [1:0] prev,
                                  output int errs, output logic [1:0] fi);
    logic [1:0] in_v;
    errs = 0;
    fi = 2'd0;
    for (int v = 0; v < 4; v++) begin
      if (!dly) in_v = 2'(v);
      else if (v == 0) in_v = prev;
      else in_v = 2'(v - 1);
      if (g[in_v] != et[v]) begin
        if (errs == 0) fi = 2'(v);
        errs++;
      end
    end
  endfunction

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ab[i], busy[i], done[i], pass[i], fidx[i], errc[i]} !== 10'd0) begin
        errors++;
        $display("FAIL reset[%0d] got %b want 0", i,
                 {ab[i], busy[i], done[i], pass[i], fidx[i], errc[i]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nand_default();
    int n0[3];
    int e;
    logic [1:0] f;
    for (int i = 0; i < 3; i++) begin
      gtt[i] = NAND_TT;
      n0[i] = done_n[i];
    end
    start_run();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %b want 1", busy[0]);
    end
    for (int v = 0; v < 4; v++) begin
      checks++;
      if (ab[0] !== 2'(v)) begin
        errors++;
        $display("FAIL ab_step[%0d] got %0d want %0d", v, ab[0], v);
      end
      repeat (3) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      ref_run(NAND_TT, ETT[i], 1'b0, 2'd0, e, f);
      checks++;
      if (done_n[i] != n0[i] + 1 || done_at[i] != e0 + 4 * (SC[i] + 1)) begin
        errors++;
        $display("FAIL nand_done[%0d] got n=%0d at %0d want n=%0d at %0d",
                 i, done_n[i] - n0[i], done_at[i] - e0, 1, 4 * (SC[i] + 1));
      end
      checks++;
      if (errc[i] !== 3'(e) || fidx[i] !== f || pass[i] !== (e == 0)) begin
        errors++;
        $display("FAIL nand_score[%0d] got e=%0d f=%0d p=%b want e=%0d f=%0d p=%b",
                 i, errc[i], fidx[i], pass[i], e, f, e == 0);
      end
    end
    checks++;
    if (ab[0] !== 2'b11 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got ab=%0d busy=%b want ab=3 busy=0", ab[0], busy[0]);
    end
  endtask

  task automatic test_stuck_one();
    gtt[0] = 4'b1111;
    start_run();
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (errc[0] !== 3'd1 || fidx[0] !== 2'd3 || pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL stuck1 got e=%0d f=%0d p=%b want e=1 f=3 p=0",
               errc[0], fidx[0], pass[0]);
    end
    gtt[0] = NAND_TT;
  endtask

  task automatic test_random();
    int n0[3];
    int e;
    logic [1:0] f;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 3; i++) begin
        gtt[i] = 4'($urandom_range(0, 15));
        n0[i] = done_n[i];
      end
      start_run();
      repeat (14) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        ref_run(gtt[i], ETT[i], 1'b0, 2'd3, e, f);
        checks++;
        if (done_n[i] != n0[i] + 1 || done_at[i] != e0 + 4 * (SC[i] + 1)) begin
          errors++;
          $display("FAIL rnd_done[%0d] got at %0d want at %0d",
                   i, done_at[i] - e0, 4 * (SC[i] + 1));
        end
        checks++;
        if (errc[i] !== 3'(e)) begin
          errors++;
          $display("FAIL rnd_err[%0d] tt=%b got %0d want %0d", i, gtt[i], errc[i], e);
        end
        checks++;
        if (fidx[i] !== f || pass[i] !== (e == 0)) begin
          errors++;
          $display("FAIL rnd_fp[%0d] tt=%b got f=%0d p=%b want f=%0d p=%b",
                   i, gtt[i], fidx[i], pass[i], f, e == 0);
        end
      end
    end
    for (int i = 0; i < 3; i++) gtt[i] = NAND_TT;
  endtask

  task automatic test_ignore_start();
    int n0;
    n0 = done_n[0];
    start_run();
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (done_n[0] != n0 + 1 || done_at[0] != e0 + 12 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got n=%0d at %0d busy=%b want n=1 at 12 busy=0",
               done_n[0] - n0, done_at[0] - e0, busy[0]);
    end
  endtask

  task automatic test_hold_start();
    int n0;
    n0 = done_n[0];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    repeat (13) @(posedge clk);
    #1;
    checks++;
    if (pass[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle got p=%b busy=%b want p=1 busy=0", pass[0], busy[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pass[0] !== 1'b0 || busy[0] !== 1'b1 || ab[0] !== 2'd0) begin
      errors++;
      $display("FAIL hold_restart got p=%b busy=%b ab=%0d want p=0 busy=1 ab=0",
               pass[0], busy[0], ab[0]);
    end
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (done_n[0] != n0 + 2 || done_at[0] != e0 + 26 || pass[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_second got n=%0d at %0d p=%b want n=2 at 26 p=1",
               done_n[0] - n0, done_at[0] - e0, pass[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = done_n[0];
    start_run();
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ab[i], busy[i], done[i], pass[i], fidx[i], errc[i]} !== 10'd0) begin
        errors++;
        $display("FAIL mid_reset[%0d] got %b want 0", i,
                 {ab[i], busy[i], done[i], pass[i], fidx[i], errc[i]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (done_n[0] != n0) begin
      errors++;
      $display("FAIL mid_no_done got %0d want 0", done_n[0] - n0);
    end
    start_run();
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (done_n[0] != n0 + 1 || done_at[0] != e0 + 12 || pass[0] !== 1'b1
        || errc[0] !== 3'd0) begin
      errors++;
      $display("FAIL mid_rerun got n=%0d at %0d p=%b e=%0d want n=1 at 12 p=1 e=0",
               done_n[0] - n0, done_at[0] - e0, pass[0], errc[0]);
    end
  endtask

  task automatic test_late_gate();
    int e;
    logic [1:0] f;
    dly_b = 1'b1;
    gtt[1] = NAND_TT;
    start_run();
    repeat (10) @(posedge clk);
    #1;
    ref_run(NAND_TT, NAND_TT, 1'b1, 2'd3, e, f);
    checks++;
    if (errc[1] !== 3'(e) || fidx[1] !== f || pass[1] !== (e == 0)) begin
      errors++;
      $display("FAIL late_gate got e=%0d f=%0d p=%b want e=%0d f=%0d p=%b",
               errc[1], fidx[1], pass[1], e, f, e == 0);
    end
    dly_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dly_b = 1'b0;
    for (int i = 0; i < 3; i++) gtt[i] = NAND_TT;
    test_reset();
    test_nand_default();
    test_stuck_one();
    test_random();
    test_ignore_start();
    test_hold_start();
    test_reset_mid();
    test_late_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
